multicycle_control_fsm: RTL and testbench

- Sequencing controller for the multi-cycle RV32I core.
- Steps each instruction through fetch, decode, execute, memory and write-back states.
- Time-shares the single ALU between PC increment, branch/jump target, address and arithmetic use. It does this by driving ALU source muxes and the 1-bit alu_ctrl_op consumed by the ALU control unit.
- Waits on a variable-latency memory handshake and halts on ECALL when x17==10 or on a memory timeout.

---
 rtl/multicycle_control_fsm_if.sv | 36 +++
 rtl/multicycle_control_fsm.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath (slave).
// The master samples instruction/status inputs and drives mux selects and strobes.
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic       bcond;
    logic       halt_req;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_ctrl_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       inst_retire;
    logic       is_halted;
    logic       mem_error;

    modport master (
        input  opcode, bcond, halt_req, mem_ready,
        output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
               alu_src_a, alu_src_b, alu_ctrl_op, reg_write, wb_sel,
               inst_retire, is_halted, mem_error
    );

    modport slave (
        output opcode, bcond, halt_req, mem_ready,
        input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
               alu_src_a, alu_src_b, alu_ctrl_op, reg_write, wb_sel,
               inst_retire, is_halted, mem_error
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: IF/ID/EX/MEM/WB/PC4/HALT with a bounded memory-wait counter.
// Strobes are decoded from the current state so memory handshakes complete in the ready cycle.
module multicycle_control_fsm #(
    parameter int MEM_WAIT_MAX = 255,
    parameter int CNT_W        = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_PC4  = 3'd5,
        S_HALT = 3'd6
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_halted_q;
    logic             mem_error_q, mem_error_d;
    logic             waiting_s;
    logic             pc_write_s, pc_source_s, i_or_d_s, mem_read_s, mem_write_s, ir_write_s;
    logic             alu_src_a_s, alu_ctrl_op_s, reg_write_s, inst_retire_s;
    logic [1:0]       alu_src_b_s, wb_sel_s;

    // Next-state, wait-counter and strobe decode.
    always_comb begin
        state_d       = state_q;
        mem_error_d   = mem_error_q;
        waiting_s     = 1'b0;
        pc_write_s    = 1'b0;
        pc_source_s   = 1'b0;
        i_or_d_s      = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        ir_write_s    = 1'b0;
        alu_src_a_s   = 1'b0;
        alu_src_b_s   = 2'd0;
        alu_ctrl_op_s = 1'b0;
        reg_write_s   = 1'b0;
        wb_sel_s      = 2'd0;
        inst_retire_s = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read_s = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_s = 1'b1;
                    state_d    = S_ID;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            S_ID: begin
                alu_src_b_s = 2'd2;
                case (bus.opcode)
                    OP_ECALL: state_d = bus.halt_req ? S_HALT : S_PC4;
                    OP_R, OP_I, OP_LOAD, OP_STORE,
                    OP_BR, OP_JAL, OP_JALR: state_d = S_EX;
                    default:  state_d = S_PC4;
                endcase
            end
            S_EX: begin
                case (bus.opcode)
                    OP_R: begin
                        alu_src_a_s = 1'b1; alu_ctrl_op_s = 1'b1; state_d = S_WB;
                    end
                    OP_I: begin
                        alu_src_a_s = 1'b1; alu_src_b_s = 2'd2; alu_ctrl_op_s = 1'b1; state_d = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a_s = 1'b1; alu_src_b_s = 2'd2; state_d = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a_s = 1'b1; alu_ctrl_op_s = 1'b1;
                        if (bus.bcond) begin
                            pc_write_s = 1'b1; pc_source_s = 1'b1; inst_retire_s = 1'b1; state_d = S_IF;
                        end else begin
                            state_d = S_PC4;
                        end
                    end
                    // rd <= PC+4 through the ALU while PC takes the ID-stage target from ALUOut.
                    OP_JAL: begin
                        alu_src_b_s = 2'd1; reg_write_s = 1'b1; wb_sel_s = 2'd2;
                        pc_write_s = 1'b1; pc_source_s = 1'b1; inst_retire_s = 1'b1; state_d = S_IF;
                    end
                    OP_JALR: begin
                        alu_src_a_s = 1'b1; alu_src_b_s = 2'd2; state_d = S_WB;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                i_or_d_s    = 1'b1;
                mem_read_s  = (bus.opcode == OP_LOAD);
                mem_write_s = (bus.opcode == OP_STORE);
                if (bus.mem_ready) begin
                    state_d = (bus.opcode == OP_LOAD) ? S_WB : S_PC4;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            S_WB: begin
                case (bus.opcode)
                    OP_R, OP_I: begin
                        reg_write_s = 1'b1; state_d = S_PC4;
                    end
                    OP_LOAD: begin
                        reg_write_s = 1'b1; wb_sel_s = 2'd1; state_d = S_PC4;
                    end
                    OP_JALR: begin
                        alu_src_b_s = 2'd1; reg_write_s = 1'b1; wb_sel_s = 2'd2;
                        pc_write_s = 1'b1; pc_source_s = 1'b1; inst_retire_s = 1'b1; state_d = S_IF;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_PC4: begin
                alu_src_b_s = 2'd1; pc_write_s = 1'b1; inst_retire_s = 1'b1; state_d = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        // A ready on the limit cycle has already moved state_d on, so it never times out.
        if (waiting_s && (cnt_q == WAIT_MAX)) begin
            state_d     = S_HALT;
            mem_error_d = 1'b1;
        end else begin
            mem_error_d = mem_error_q;
        end
        if (state_d != state_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (waiting_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, wait counter and sticky status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IF;
            cnt_q       <= {CNT_W{1'b0}};
            is_halted_q <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_halted_q <= (state_d == S_HALT);
            mem_error_q <= mem_error_d;
        end
    end

    assign bus.pc_write    = reset & pc_write_s;
    assign bus.pc_source   = reset & pc_source_s;
    assign bus.i_or_d      = reset & i_or_d_s;
    assign bus.mem_read    = reset & mem_read_s;
    assign bus.mem_write   = reset & mem_write_s;
    assign bus.ir_write    = reset & ir_write_s;
    assign bus.alu_src_a   = reset & alu_src_a_s;
    assign bus.alu_src_b   = reset ? alu_src_b_s : 2'd0;
    assign bus.alu_ctrl_op = reset & alu_ctrl_op_s;
    assign bus.reg_write   = reset & reg_write_s;
    assign bus.wb_sel      = reset ? wb_sel_s : 2'd0;
    assign bus.inst_retire = reset & inst_retire_s;
    assign bus.is_halted   = is_halted_q;
    assign bus.mem_error   = mem_error_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Trace-driven bench: each instruction is expanded into a per-cycle list of inputs and
// expected outputs from the instruction-class rules, then replayed against the controller.
module tb_multicycle_control_fsm;
    localparam int MAXW = 4;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef struct packed {
        logic        rst;
        logic        mr;
        logic        bc;
        logic        hr;
        logic [6:0]  op;
        logic [15:0] exp;
    } ent_t;

    logic clk;
    logic reset;
    multicycle_control_fsm_if bus ();
    ent_t q[$];
    logic m_halt;
    logic m_err;
    int   n_total;
    int   n_bad;

    multicycle_control_fsm #(.MEM_WAIT_MAX(MAXW), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Strobe vector: pcw pcs iod mr mw irw a b[2] op rw wb[2] ret
    function automatic logic [13:0] v(input logic pcw, input logic pcs, input logic iod,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic a, input logic [1:0] b, input logic op,
                                      input logic rw, input logic [1:0] wb, input logic ret);
        return {pcw, pcs, iod, mr, mw, irw, a, b, op, rw, wb, ret};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic mr, input logic bc, input logic hr,
                       input logic [6:0] op, input logic [13:0] s);
        ent_t e;
        e.rst = rst; e.mr = mr; e.bc = bc; e.hr = hr; e.op = op;
        e.exp = {s, m_halt, m_err};
        q.push_back(e);
    endtask

    task automatic add_reset(input logic [6:0] op);
        add(1'b0, rb(), rb(), rb(), op, 14'd0);
        m_halt = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic halt_tail(input logic [6:0] op);
        for (int k = 0; k < 3; k++) add(1'b1, rb(), rb(), rb(), op, 14'd0);
        add_reset(op);
    endtask

    // A request waits 'lat' cycles; the (MAXW+1)-th consecutive unready cycle is fatal.
    task automatic wait_phase(input logic [6:0] op, input int lat, input logic [13:0] vw,
                              input logic [13:0] vd, output bit ok);
        ok = 1'b1;
        for (int k = 0; k <= lat; k++) begin
            if (k == lat) begin
                add(1'b1, 1'b1, rb(), rb(), op, vd);
            end else begin
                add(1'b1, 1'b0, rb(), rb(), op, vw);
                if (k == MAXW) begin
                    m_halt = 1'b1;
                    m_err  = 1'b1;
                    ok     = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic gen_instr(input logic [6:0] op, input int flat, input int mlat,
                             input logic bc, input logic hr);
        bit ok;
        logic [13:0] pc4;
        pc4 = v(1,0,0,0,0,0,0,2'd1,0,0,2'd0,1);
        wait_phase(op, flat, v(0,0,0,1,0,0,0,2'd0,0,0,2'd0,0),
                   v(0,0,0,1,0,1,0,2'd0,0,0,2'd0,0), ok);
        if (!ok) begin
            halt_tail(op);
            return;
        end
        add(1'b1, rb(), rb(), (op == OP_ECALL) ? hr : rb(), op, v(0,0,0,0,0,0,0,2'd2,0,0,2'd0,0));
        case (op)
            OP_ECALL: begin
                if (hr) begin
                    m_halt = 1'b1;
                    halt_tail(op);
                end else begin
                    add(1'b1, rb(), rb(), rb(), op, pc4);
                end
            end
            OP_R, OP_I: begin
                add(1'b1, rb(), rb(), rb(), op,
                    v(0,0,0,0,0,0,1,(op == OP_I) ? 2'd2 : 2'd0,1,0,2'd0,0));
                add(1'b1, rb(), rb(), rb(), op, v(0,0,0,0,0,0,0,2'd0,0,1,2'd0,0));
                add(1'b1, rb(), rb(), rb(), op, pc4);
            end
            OP_LOAD, OP_STORE: begin
                add(1'b1, rb(), rb(), rb(), op, v(0,0,0,0,0,0,1,2'd2,0,0,2'd0,0));
                if (op == OP_LOAD) begin
                    wait_phase(op, mlat, v(0,0,1,1,0,0,0,2'd0,0,0,2'd0,0),
                               v(0,0,1,1,0,0,0,2'd0,0,0,2'd0,0), ok);
                end else begin
                    wait_phase(op, mlat, v(0,0,1,0,1,0,0,2'd0,0,0,2'd0,0),
                               v(0,0,1,0,1,0,0,2'd0,0,0,2'd0,0), ok);
                end
                if (!ok) begin
                    halt_tail(op);
                    return;
                end
                if (op == OP_LOAD) add(1'b1, rb(), rb(), rb(), op, v(0,0,0,0,0,0,0,2'd0,0,1,2'd1,0));
                add(1'b1, rb(), rb(), rb(), op, pc4);
            end
            OP_BR: begin
                if (bc) begin
                    add(1'b1, rb(), 1'b1, rb(), op, v(1,1,0,0,0,0,1,2'd0,1,0,2'd0,1));
                end else begin
                    add(1'b1, rb(), 1'b0, rb(), op, v(0,0,0,0,0,0,1,2'd0,1,0,2'd0,0));
                    add(1'b1, rb(), rb(), rb(), op, pc4);
                end
            end
            OP_JAL: add(1'b1, rb(), rb(), rb(), op, v(1,1,0,0,0,0,0,2'd1,0,1,2'd2,1));
            OP_JALR: begin
                add(1'b1, rb(), rb(), rb(), op, v(0,0,0,0,0,0,1,2'd2,0,0,2'd0,0));
                add(1'b1, rb(), rb(), rb(), op, v(1,1,0,0,0,0,0,2'd1,0,1,2'd2,1));
            end
            default: add(1'b1, rb(), rb(), rb(), op, pc4);
        endcase
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [6:0] op;
        logic [15:0] got;
        n_total = 0;
        n_bad   = 0;
        m_halt  = 1'b0;
        m_err   = 1'b0;
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_ECALL, OP_LUI};

        // Directed cases from the block's intended use, then randomized traffic.
        add_reset(OP_I);
        gen_instr(OP_I, 0, 0, 1'b0, 1'b0);
        gen_instr(OP_LOAD, 0, 3, 1'b0, 1'b0);
        gen_instr(OP_BR, 0, 0, 1'b1, 1'b0);
        gen_instr(OP_BR, 0, 0, 1'b0, 1'b0);
        gen_instr(OP_JALR, 1, 0, 1'b0, 1'b0);
        gen_instr(OP_JAL, 0, 0, 1'b0, 1'b0);
        gen_instr(OP_ECALL, 0, 0, 1'b0, 1'b1);
        gen_instr(OP_ECALL, 0, 0, 1'b0, 1'b0);
        gen_instr(OP_LUI, 2, 0, 1'b0, 1'b0);
        gen_instr(OP_R, MAXW + 1, 0, 1'b0, 1'b0);
        gen_instr(OP_R, MAXW, 0, 1'b0, 1'b0);
        gen_instr(OP_STORE, 0, MAXW, 1'b0, 1'b0);
        gen_instr(OP_LOAD, 0, MAXW + 1, 1'b0, 1'b0);
        // Reset while a fetch is waiting, then a full-limit wait must still succeed.
        add(1'b1, 1'b0, rb(), rb(), OP_I, v(0,0,0,1,0,0,0,2'd0,0,0,2'd0,0));
        add(1'b1, 1'b0, rb(), rb(), OP_I, v(0,0,0,1,0,0,0,2'd0,0,0,2'd0,0));
        add(1'b1, 1'b0, rb(), rb(), OP_I, v(0,0,0,1,0,0,0,2'd0,0,0,2'd0,0));
        add_reset(OP_I);
        gen_instr(OP_I, MAXW, 0, 1'b0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            else op = ops[$urandom_range(0, 8)];
            gen_instr(op, int'($urandom_range(0, MAXW + 1)), int'($urandom_range(0, MAXW + 1)),
                      rb(), rb());
        end

        reset         = 1'b0;
        bus.opcode    = OP_I;
        bus.bcond     = 1'b0;
        bus.halt_req  = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);

        foreach (q[i]) begin
            @(negedge clk);
            reset         = q[i].rst;
            bus.mem_ready = q[i].mr;
            bus.bcond     = q[i].bc;
            bus.halt_req  = q[i].hr;
            bus.opcode    = q[i].op;
            #2;
            got = {bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
                   bus.ir_write, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl_op,
                   bus.reg_write, bus.wb_sel, bus.inst_retire, bus.is_halted, bus.mem_error};
            check_eq($sformatf("cyc%0d_op%07b", i, q[i].op), got, q[i].exp);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
